debug_slave: RTL and testbench

- CPU-side endpoint of the 2-bit-address debug bus driven by the debug controller.
- Decodes bus register writes and executes commands against the core: halt, run, single-step, register file read/write and 32-bit memory read/write.
- Completes each command with a four-phase req/ack handshake.
- Sits between the debug bus and the core's run-control, register-file debug port and memory arbiter debug port.

---
 rtl/debug_pkg.sv | 30 +++
 rtl/debug_step_timer.sv | 28 ++
 rtl/debug_slave.sv | 157 +++++++++++++++
 tb/tb_debug_slave.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// debug_pkg: shared opcodes, bus register addresses and FSM encoding for the debug slave
package debug_pkg;

    localparam logic [3:0] OP_HALT   = 4'd0;
    localparam logic [3:0] OP_RUN    = 4'd1;
    localparam logic [3:0] OP_STEP   = 4'd2;
    localparam logic [3:0] OP_RD_REG = 4'd3;
    localparam logic [3:0] OP_WR_REG = 4'd4;
    localparam logic [3:0] OP_RD_MEM = 4'd5;
    localparam logic [3:0] OP_WR_MEM = 4'd6;

    localparam logic [1:0] A_CMD   = 2'd0;
    localparam logic [1:0] A_ADDR  = 2'd1;
    localparam logic [1:0] A_WDATA = 2'd2;
    localparam logic [1:0] A_RDATA = 2'd3;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_HALT      = 4'd1;
    localparam logic [3:0] S_STEP_FALL = 4'd2;
    localparam logic [3:0] S_STEP_RISE = 4'd3;
    localparam logic [3:0] S_REG_WAIT  = 4'd4;
    localparam logic [3:0] S_REG_CAP   = 4'd5;
    localparam logic [3:0] S_MEM       = 4'd6;
    localparam logic [3:0] S_ACK       = 4'd7;

    function automatic logic needs_stop(input logic [3:0] op);
        return op >= OP_RD_REG && op <= OP_WR_MEM;
    endfunction

endpackage

// File: rtl/debug_step_timer.sv
// debug_step_timer: loadable down-counter that flags expiry when it reaches zero
module debug_step_timer
    import debug_pkg::*;
#(
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired
);

    logic [WIDTH-1:0] cnt;

    // reload on request, otherwise count down and park at zero
    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - WIDTH'(1);
    end

    assign expired = cnt == '0;

endmodule

// File: rtl/debug_slave.sv
// debug_slave: debug bus endpoint executing run-control, register and memory commands on the core
module debug_slave
    import debug_pkg::*;
#(
    parameter int unsigned STEP_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  dbg_addr,
    input  logic [31:0] dbg_din,
    input  logic        dbg_wr_en,
    input  logic        dbg_req,
    output logic [31:0] dbg_dout,
    output logic        dbg_ack,
    output logic        cpu_halt,
    input  logic        cpu_stopped,
    output logic        cpu_run,
    output logic        cpu_step,
    output logic [3:0]  reg_sel,
    output logic        reg_wr_en,
    output logic [31:0] reg_wr_val,
    input  logic [31:0] reg_rd_val,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    output logic        mem_wr_en,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [31:0] mem_rd_data
);

    localparam int TW = $clog2(STEP_TIMEOUT + 1);

    logic [3:0]  state;
    logic [31:0] address, wdata, rdata, rd_mux;
    logic        step_timeout, step_expired, accept;
    logic [3:0]  op;

    assign op      = dbg_din[3:0];
    assign accept  = state == S_IDLE && dbg_req && dbg_wr_en && dbg_addr == A_CMD;
    assign dbg_ack = state == S_ACK;
    assign rd_mux  = dbg_addr == A_CMD   ? {28'b0, 2'b0, step_timeout, cpu_stopped} :
                     dbg_addr == A_ADDR  ? address :
                     dbg_addr == A_WDATA ? wdata : rdata;

    debug_step_timer #(.WIDTH(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept && op == OP_STEP),
        .load_val (TW'(STEP_TIMEOUT)),
        .expired  (step_expired)
    );

    // bus register writes only happen outside a command request
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            address <= '0;
            wdata   <= '0;
        end else if (dbg_wr_en && !dbg_req) begin
            if (dbg_addr == A_ADDR)
                address <= dbg_din;
            if (dbg_addr == A_WDATA)
                wdata <= dbg_din;
        end
    end

    // registered read-back of the selected bus register
    always_ff @(posedge clk) begin
        if (!rst_n)
            dbg_dout <= '0;
        else
            dbg_dout <= rd_mux;
    end

    // command sequencer: dispatch on accept, wait on core/memory, then hold ack until req drops
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            rdata        <= '0;
            step_timeout <= 1'b0;
            cpu_halt     <= 1'b0;
            cpu_run      <= 1'b0;
            cpu_step     <= 1'b0;
            reg_sel      <= '0;
            reg_wr_en    <= 1'b0;
            reg_wr_val   <= '0;
            mem_addr     <= '0;
            mem_wr_data  <= '0;
            mem_wr_en    <= 1'b0;
            mem_req      <= 1'b0;
        end else begin
            cpu_run   <= 1'b0;
            cpu_step  <= 1'b0;
            reg_wr_en <= 1'b0;
            case (state)
                S_IDLE: if (accept) begin
                    step_timeout <= 1'b0;
                    if (op == OP_HALT) begin
                        cpu_halt <= 1'b1;
                        state    <= S_HALT;
                    end else if (op == OP_RUN) begin
                        cpu_halt <= 1'b0;
                        cpu_run  <= 1'b1;
                        state    <= S_ACK;
                    end else if (op == OP_STEP) begin
                        cpu_halt <= 1'b0;
                        cpu_step <= 1'b1;
                        state    <= S_STEP_FALL;
                    end else if (!needs_stop(op) || !cpu_stopped) begin
                        state <= S_ACK;
                    end else if (op == OP_RD_REG) begin
                        reg_sel <= address[3:0];
                        state   <= S_REG_WAIT;
                    end else if (op == OP_WR_REG) begin
                        reg_sel    <= address[3:0];
                        reg_wr_val <= wdata;
                        reg_wr_en  <= 1'b1;
                        state      <= S_ACK;
                    end else begin
                        mem_addr    <= address;
                        mem_wr_data <= wdata;
                        mem_wr_en   <= op == OP_WR_MEM;
                        mem_req     <= 1'b1;
                        state       <= S_MEM;
                    end
                end
                S_HALT: if (cpu_stopped) state <= S_ACK;
                S_STEP_FALL: if (step_expired) begin
                    step_timeout <= 1'b1;
                    state        <= S_ACK;
                end else if (!cpu_stopped) begin
                    state <= S_STEP_RISE;
                end
                S_STEP_RISE: if (cpu_stopped) begin
                    state <= S_ACK;
                end else if (step_expired) begin
                    step_timeout <= 1'b1;
                    state        <= S_ACK;
                end
                S_REG_WAIT: state <= S_REG_CAP;
                S_REG_CAP: begin
                    rdata <= reg_rd_val;
                    state <= S_ACK;
                end
                S_MEM: if (mem_ack) begin
                    mem_req   <= 1'b0;
                    mem_wr_en <= 1'b0;
                    if (!mem_wr_en)
                        rdata <= mem_rd_data;
                    state <= S_ACK;
                end
                S_ACK: if (!dbg_req) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_slave.sv
// tb_debug_slave: scoreboard bench for the debug slave with core, register-file and memory models
module tb_debug_slave;

    localparam int TO = 1024;

    typedef struct { string name; int lo; int hi; } ack_t;
    typedef struct { logic [3:0] sel; logic [31:0] val; } wr_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; logic we; } mem_t;
    typedef struct { int cyc; string name; int sel; logic [31:0] exp; } probe_t;

    logic        clk, rst_n, dbg_wr_en, dbg_req, dbg_ack, cpu_halt, cpu_stopped, cpu_run, cpu_step;
    logic [1:0]  dbg_addr;
    logic [31:0] dbg_din, dbg_dout, reg_wr_val, reg_rd_val, mem_addr, mem_wr_data, mem_rd_data;
    logic [3:0]  reg_sel;
    logic        reg_wr_en, mem_wr_en, mem_req, mem_ack;

    ack_t   ack_q[$];
    wr_t    wr_q[$];
    mem_t   mem_q[$];
    probe_t probe_q[$];

    int cyc = 0;
    int n_cmp = 0, n_bad = 0, n_timeout = 0;
    int lat = 0, run_cnt = 0, step_cnt = 0, mem_delay = 0, mcnt = 0;
    logic req_d = 0, ack_d = 0, mreq_d = 0, mack_d = 0, done = 0;
    logic [31:0] mem_word = 0;
    logic [31:0] rf [16];
    int          dl [3] = '{0, 1, 7};
    logic [31:0] vl [3] = '{32'h1234_5678, 32'hA5A5_0001, 32'h0BAD_F00D};

    debug_slave #(.STEP_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .dbg_addr(dbg_addr), .dbg_din(dbg_din), .dbg_wr_en(dbg_wr_en),
        .dbg_req(dbg_req), .dbg_dout(dbg_dout), .dbg_ack(dbg_ack), .cpu_halt(cpu_halt),
        .cpu_stopped(cpu_stopped), .cpu_run(cpu_run), .cpu_step(cpu_step), .reg_sel(reg_sel),
        .reg_wr_en(reg_wr_en), .reg_wr_val(reg_wr_val), .reg_rd_val(reg_rd_val), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en), .mem_req(mem_req), .mem_ack(mem_ack),
        .mem_rd_data(mem_rd_data)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // register file model: one-cycle registered read of reg_sel
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) rf[i] <= 32'h100 + i;
        end else if (reg_wr_en) begin
            rf[reg_sel] <= reg_wr_val;
        end
        reg_rd_val <= rf[reg_sel];
    end

    // memory model: acks mem_delay cycles after mem_req is seen
    initial begin
        mem_ack = 0;
        mem_rd_data = 0;
        forever begin
            @(posedge clk); #1;
            if (mem_ack) begin
                mem_ack = 0;
                mcnt = 0;
            end else if (mem_req) begin
                if (mcnt == mem_delay) begin
                    mem_ack = 1;
                    if (mem_wr_en) mem_word = mem_wr_data;
                    else mem_rd_data = mem_word;
                end else mcnt++;
            end
        end
    end

    function automatic logic [31:0] pval(input int sel);
        return sel == 0 ? dbg_dout : sel == 1 ? {31'b0, dbg_ack} : sel == 2 ? {31'b0, cpu_halt} :
               sel == 3 ? 32'(run_cnt) : 32'(step_cnt);
    endfunction

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic probe(input string n, input int sel, input logic [31:0] e);
        probe_q.push_back('{cyc, n, sel, e});
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        dbg_addr = a; dbg_din = d; dbg_wr_en = 1;
        tick;
        dbg_wr_en = 0;
    endtask

    task automatic bus_read(input string n, input logic [1:0] a, input logic [31:0] e);
        dbg_addr = a;
        tick; tick;
        probe(n, 0, e);
        tick;
    endtask

    task automatic issue(input string n, input logic [3:0] op, input int lo, input int hi);
        ack_q.push_back('{n, lo, hi});
        dbg_addr = 0; dbg_din = {28'b0, op}; dbg_wr_en = 1; dbg_req = 1;
        for (int i = 0; i < 3000 && !dbg_ack; i++) tick;
        if (!dbg_ack) begin
            n_timeout++;
            void'(ack_q.pop_back());
            $display("FAIL %s ack wait: got no ack, required ack within 3000 cycles", n);
        end
        probe({n, " ack hold"}, 1, 1);
        dbg_req = 0; dbg_wr_en = 0;
        tick;
        probe({n, " ack drop"}, 1, 0);
        tick;
    endtask

    // monitor: pops scoreboard queues whenever the DUT presents ack, writes, memory handshakes or a probe is due
    initial begin
        ack_t a; wr_t w; mem_t m; probe_t p; logic [31:0] v;
        forever begin
            @(negedge clk);
            if (cpu_run) run_cnt++;
            if (cpu_step) step_cnt++;
            lat = (dbg_req && !req_d) ? 0 : lat + 1;
            req_d = dbg_req;
            if (dbg_ack && !ack_d) begin
                n_cmp++;
                if (ack_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected ack: got ack, required none");
                end else begin
                    a = ack_q.pop_front();
                    if (lat < a.lo || lat > a.hi) begin
                        n_bad++;
                        $display("FAIL %s latency: got %0d, required %0d..%0d", a.name, lat, a.lo, a.hi);
                    end
                end
            end
            ack_d = dbg_ack;
            if (reg_wr_en) begin
                n_cmp++;
                if (wr_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL reg write: got unexpected write sel=%0d, required none", reg_sel);
                end else begin
                    w = wr_q.pop_front();
                    if (reg_sel !== w.sel || reg_wr_val !== w.val) begin
                        n_bad++;
                        $display("FAIL reg write: got sel=%0d val=%h, required sel=%0d val=%h", reg_sel, reg_wr_val, w.sel, w.val);
                    end
                end
            end
            if (mem_req && mem_ack) begin
                n_cmp++;
                if (mem_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL mem access: got unexpected access at %h, required none", mem_addr);
                end else begin
                    m = mem_q.pop_front();
                    if (mem_addr !== m.addr || mem_wr_en !== m.we || (m.we && mem_wr_data !== m.data)) begin
                        n_bad++;
                        $display("FAIL mem access: got addr=%h we=%b data=%h, required addr=%h we=%b data=%h", mem_addr, mem_wr_en, mem_wr_data, m.addr, m.we, m.data);
                    end
                end
            end else if (mem_req && mem_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL mem_req: got request at %h, required none", mem_addr);
            end
            if (mreq_d && !mack_d && !mem_req) begin
                n_cmp++; n_bad++;
                $display("FAIL mem_req hold: got drop without ack, required held until ack");
            end
            mreq_d = mem_req;
            mack_d = mem_ack;
            while (probe_q.size() > 0 && probe_q[0].cyc <= cyc) begin
                p = probe_q.pop_front();
                v = pval(p.sel);
                n_cmp++;
                if (v !== p.exp) begin
                    n_bad++;
                    $display("FAIL %s: got %h, required %h", p.name, v, p.exp);
                end
            end
            if (done) begin
                n_cmp++;
                if (n_timeout != 0 || ack_q.size() != 0 || wr_q.size() != 0 || mem_q.size() != 0) begin
                    n_bad++;
                    $display("FAIL leftovers: got timeouts=%0d acks=%0d writes=%0d mem=%0d, required all 0", n_timeout, ack_q.size(), wr_q.size(), mem_q.size());
                end
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
                $finish;
            end
        end
    end

    // directed stimulus
    initial begin
        rst_n = 0; dbg_req = 1; dbg_wr_en = 1; dbg_addr = 0; dbg_din = 0; cpu_stopped = 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            probe("rst ack", 1, 0); probe("rst halt", 2, 0); probe("rst dout", 0, 0);
        end
        rst_n = 1; dbg_req = 0; dbg_wr_en = 0;
        tick;
        probe("post rst ack", 1, 0); probe("post rst halt", 2, 0); probe("post rst dout", 0, 0);

        bus_write(1, 32'd3);
        bus_write(2, 32'hDEAD_BEEF);
        bus_write(3, 32'h55);
        bus_write(0, 32'h4);
        bus_read("address reg", 1, 32'd3);
        bus_read("wdata reg", 2, 32'hDEAD_BEEF);
        bus_read("rdata ignores write", 3, 32'h0);

        fork
            issue("halt", 0, 6, 6);
            begin repeat (5) tick; cpu_stopped = 1; end
        join
        probe("halt level", 2, 1);
        bus_read("status halted", 0, 32'h1);

        wr_q.push_back('{4'd3, 32'hDEAD_BEEF});
        issue("write_reg", 4, 1, 1);
        issue("read_reg", 3, 3, 3);
        bus_read("rdata reg", 3, 32'hDEAD_BEEF);

        bus_write(1, 32'h1000);
        for (int k = 0; k < 3; k++) begin
            bus_write(2, vl[k]);
            mem_q.push_back('{32'h1000, vl[k], 1'b1});
            mem_delay = 0;
            issue("write_mem", 6, 2, 2);
            mem_q.push_back('{32'h1000, 32'h0, 1'b0});
            mem_delay = dl[k];
            issue("read_mem", 5, 2 + dl[k], 2 + dl[k]);
            bus_read("rdata mem", 3, vl[k]);
        end
        mem_delay = 0;

        issue("run", 1, 1, 1);
        probe("run pulses", 3, 1); probe("halt after run", 2, 0);

        fork
            issue("step", 2, 5, 5);
            begin
                for (int i = 0; i < 20 && !cpu_step; i++) tick;
                cpu_stopped = 0;
                repeat (3) tick;
                cpu_stopped = 1;
            end
        join
        probe("step pulses", 4, 1);
        bus_read("status after step", 0, 32'h1);

        issue("step timeout", 2, TO, TO + 3);
        probe("step pulses 2", 4, 2);
        bus_read("status timeout", 0, 32'h3);

        issue("halt clears timeout", 0, 2, 2);
        probe("halt again", 2, 1);
        bus_read("status cleared", 0, 32'h1);

        cpu_stopped = 0;
        tick;
        issue("read_mem running", 5, 1, 1);
        issue("read_reg running", 3, 1, 1);
        issue("opcode F", 15, 1, 1);
        bus_read("rdata unchanged", 3, 32'h0BAD_F00D);
        bus_read("status running", 0, 32'h0);
        done = 1;
    end

endmodule
